// File: rtl/micro_param_pkg.sv
// Shared encodings for the micro_param accumulator core: opcodes, branch
// conditions, run-state encoding and instruction field placement.
package micro_param_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    CND_ALWAYS = 2'd0,
    CND_Z      = 2'd1,
    CND_NZ     = 2'd2,
    CND_C      = 2'd3
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Control bits sit above the DATA_W-wide addr/lit field, MSB first.
  typedef struct packed {
    opcode_t op;
    logic    pc_sel;
    cond_t   cond;
    logic    mem_lit;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic int inst_w(int dw);
    return dw + CTRL_W;
  endfunction

  function automatic int ctrl_lsb(int dw);
    return dw;
  endfunction

  function automatic logic cond_met(cond_t c, logic z, logic cy);
    case (c)
      CND_ALWAYS: return 1'b1;
      CND_Z:      return z;
      CND_NZ:     return !z;
      default:    return cy;
    endcase
  endfunction

endpackage

// File: rtl/micro_param_if.sv
// Host-side bus of micro_param: memory load ports, start pulse and the
// architectural state the core exposes for observation.
interface micro_param_if
  import micro_param_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  parameter int DMEM_DEPTH = 16
);
  localparam int INST_W = inst_w(DATA_W);
  localparam int DA_W   = $clog2(DMEM_DEPTH);

  logic              start;
  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [INST_W-1:0] prog_data;
  logic              dmem_we;
  logic [DA_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_data;

  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] w;
  logic [INST_W-1:0] inst;
  logic              is_zero;
  logic              carry;
  logic              running;
  logic              halted;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] d;

  modport master (
    output start, prog_we, prog_addr, prog_data, dmem_we, dmem_addr, dmem_data,
    input  pc, w, inst, is_zero, carry, running, halted, a, b, d
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, dmem_we, dmem_addr, dmem_data,
    output pc, w, inst, is_zero, carry, running, halted, a, b, d
  );
endinterface

// File: rtl/micro_param_alu.sv
// Combinational ALU; carry passes through untouched for ops that do not
// define it so the top can write the flag unconditionally on ADD/SUB.
module micro_param_alu
  import micro_param_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic [DATA_W-1:0] d,
  output logic              carry_out
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    d         = a;
    carry_out = carry_in;
    case (op)
      OP_LOAD:  d = a;
      OP_STORE: d = b;
      OP_ADD: begin
        d         = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
      end
      // Carry means "no borrow", i.e. a >= b unsigned.
      OP_SUB: begin
        d         = diff[DATA_W-1:0];
        carry_out = ~diff[DATA_W];
      end
      OP_AND:   d = a & b;
      OP_OR:    d = a | b;
      OP_XOR:   d = a ^ b;
      OP_HALT:  d = a;
    endcase
  end
endmodule

// File: rtl/micro_param.sv
// Single-cycle accumulator core with host-loadable program/data memories and
// an IDLE/RUN/HALTED control FSM.
module micro_param
  import micro_param_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  parameter int PMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  micro_param_if.slave bus
);
  localparam int INST_W   = inst_w(DATA_W);
  localparam int DA_W     = $clog2(DMEM_DEPTH);
  localparam int PA_W     = (PMEM_DEPTH > 1) ? $clog2(PMEM_DEPTH) : 1;
  localparam int CTRL_LSB = ctrl_lsb(DATA_W);

  logic [INST_W-1:0] pmem [PMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] w;
  logic              is_zero;
  logic              carry;

  logic              fetch_ok;
  logic              prog_ok;
  logic              host_ok;
  logic [INST_W-1:0] inst;
  ctrl_t             ctl;
  logic [DATA_W-1:0] lit;
  logic [DA_W-1:0]   daddr;
  logic              exec;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] d;
  logic              carry_out;

  // Fetch beyond the program image reads all-ones, which decodes as HALT.
  assign fetch_ok = {1'b0, pc} < (PC_W+1)'(PMEM_DEPTH);
  assign prog_ok  = {1'b0, bus.prog_addr} < (PC_W+1)'(PMEM_DEPTH);
  assign inst     = fetch_ok ? pmem[pc[PA_W-1:0]] : '1;

  assign ctl   = ctrl_t'(inst[CTRL_LSB +: CTRL_W]);
  assign lit   = inst[DATA_W-1:0];
  assign daddr = lit[DA_W-1:0];

  // The all-ones fill carries cond=C, so out-of-range fetch forces execution.
  assign exec = !fetch_ok || cond_met(ctl.cond, is_zero, carry);

  assign a = ctl.mem_lit ? dmem[daddr] : lit;
  assign b = ctl.pc_sel ? DATA_W'(pc) : w;

  micro_param_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (ctl.op),
    .a         (a),
    .b         (b),
    .carry_in  (carry),
    .d         (d),
    .carry_out (carry_out)
  );

  assign host_ok = (state != ST_RUN);

  always_ff @(posedge clk) begin
    if (host_ok && bus.prog_we && prog_ok)
      pmem[bus.prog_addr[PA_W-1:0]] <= bus.prog_data;
  end

  // Host and STORE never collide: host writes are only honoured outside RUN.
  always_ff @(posedge clk) begin
    if (host_ok && bus.dmem_we)
      dmem[bus.dmem_addr] <= bus.dmem_data;
    else if (state == ST_RUN && !reset && exec && ctl.op == OP_STORE)
      dmem[daddr] <= b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      w       <= '0;
      is_zero <= 1'b0;
      carry   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   if (bus.start) state <= ST_RUN;
        ST_HALTED: if (bus.start) begin
          state <= ST_RUN;
          pc    <= pc + PC_W'(1);
        end
        ST_RUN: begin
          if (!exec || ctl.op == OP_STORE) begin
            pc <= pc + PC_W'(1);
          end else if (ctl.op == OP_HALT) begin
            state <= ST_HALTED;
          end else begin
            if (ctl.pc_sel) begin
              pc <= d[PC_W-1:0];
            end else begin
              w  <= d;
              pc <= pc + PC_W'(1);
            end
            is_zero <= (d == '0);
            if (ctl.op == OP_ADD || ctl.op == OP_SUB) carry <= carry_out;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc      = pc;
  assign bus.w       = w;
  assign bus.inst    = inst;
  assign bus.is_zero = is_zero;
  assign bus.carry   = carry;
  assign bus.running = (state == ST_RUN);
  assign bus.halted  = (state == ST_HALTED);
  assign bus.a       = a;
  assign bus.b       = b;
  assign bus.d       = d;
endmodule

// File: tb/tb_micro_param.sv
// Directed programs for micro_param; expectations are queued by the stimulus
// and checked by an independent negedge monitor.
module tb_micro_param;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  micro_param_if #(.DATA_W(8), .PC_W(8), .DMEM_DEPTH(16)) bus ();

  micro_param #(.DATA_W(8), .PC_W(8), .PMEM_DEPTH(32), .DMEM_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [2:0] L = 3'd0, ST = 3'd1, AD = 3'd2, SB = 3'd3, HL = 3'd7;
  localparam logic [1:0] AL = 2'd0, CZ = 2'd1, CNZ = 2'd2, CC = 2'd3;

  typedef struct {
    string       name;
    logic [7:0]  pc, w;
    logic        z, c, run, hlt;
    bit          chk_inst;
    logic [14:0] inst;
    bit          chk_abd;
    logic [7:0]  a, b, d;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  logic [14:0] prog [32];

  function automatic logic [14:0] mk(logic [2:0] op, logic pcw, logic [1:0] cnd,
                                     logic ml, logic [7:0] lit);
    return {op, pcw, cnd, ml, lit};
  endfunction

  task automatic chk(input string nm, input string f, input logic [14:0] got,
                     input logic [14:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got %0h want %0h", nm, f, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      chk(cur.name, "pc",      15'(bus.pc),      15'(cur.pc));
      chk(cur.name, "w",       15'(bus.w),       15'(cur.w));
      chk(cur.name, "is_zero", 15'(bus.is_zero), 15'(cur.z));
      chk(cur.name, "carry",   15'(bus.carry),   15'(cur.c));
      chk(cur.name, "running", 15'(bus.running), 15'(cur.run));
      chk(cur.name, "halted",  15'(bus.halted),  15'(cur.hlt));
      if (cur.chk_inst) chk(cur.name, "inst", bus.inst, cur.inst);
      if (cur.chk_abd) begin
        chk(cur.name, "a", 15'(bus.a), 15'(cur.a));
        chk(cur.name, "b", 15'(bus.b), 15'(cur.b));
        chk(cur.name, "d", 15'(bus.d), 15'(cur.d));
      end
    end
  end

  task automatic push_exp(input string nm, input logic [7:0] pc, input logic [7:0] w,
                          input logic z, input logic c, input logic run, input logic hlt);
    exp_t e;
    e.name = nm; e.pc = pc; e.w = w; e.z = z; e.c = c; e.run = run; e.hlt = hlt;
    e.chk_inst = 1'b0; e.inst = '0; e.chk_abd = 1'b0; e.a = '0; e.b = '0; e.d = '0;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = mk(HL, 1'b0, AL, 1'b0, 8'h00);
  endtask

  task automatic pwr(input int addr, input logic [14:0] data);
    bus.prog_we = 1'b1; bus.prog_addr = addr[7:0]; bus.prog_data = data;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic dwr(input int addr, input logic [7:0] data);
    bus.dmem_we = 1'b1; bus.dmem_addr = addr[3:0]; bus.dmem_data = data;
    tick();
    bus.dmem_we = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) pwr(i, prog[i]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    int n = 0;
    while (!bus.halted && n < 200) begin
      tick();
      n++;
    end
    if (!bus.halted) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout halted got 0 want 1", nm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.dmem_we = 1'b0; bus.dmem_addr = '0; bus.dmem_data = '0;
    do_reset();
    push_exp("reset", 8'h00, 8'h00, 0, 0, 0, 0);

    // Equality if/else: a=dmem[0]=10, b=dmem[1]=9; unequal path copies a to b.
    clear_prog();
    prog[0] = mk(L,  0, AL, 1, 8'd0);
    prog[1] = mk(SB, 0, AL, 1, 8'd1);
    prog[2] = mk(L,  1, CZ, 0, 8'd8);
    prog[3] = mk(L,  0, AL, 1, 8'd0);
    prog[4] = mk(ST, 0, AL, 0, 8'd1);
    prog[6] = mk(L,  0, AL, 1, 8'd1);
    prog[8] = mk(L,  0, AL, 0, 8'd0);
    load_prog();
    dwr(0, 8'd10);
    dwr(1, 8'd9);
    pulse_start();
    wait_halt("eq_halt");
    push_exp("eq_halt", 8'd5, 8'd10, 0, 0, 0, 1);
    pulse_start();
    wait_halt("eq_b");
    push_exp("eq_b", 8'd7, 8'd10, 0, 0, 0, 1);

    // ADD/SUB carry and zero, HALT hold, host write while halted, resume.
    do_reset();
    clear_prog();
    prog[0] = mk(L,  0, AL, 0, 8'h01);
    prog[1] = mk(AD, 0, AL, 0, 8'hFF);
    prog[3] = mk(L,  0, AL, 0, 8'h05);
    prog[4] = mk(SB, 0, AL, 0, 8'h03);
    prog[6] = mk(L,  0, AL, 1, 8'h03);
    load_prog();
    pulse_start();
    wait_halt("add");
    push_exp("add", 8'd2, 8'h00, 1, 1, 0, 1);
    sb[$].chk_inst = 1'b1;
    sb[$].inst = mk(HL, 0, AL, 0, 8'h00);
    pulse_start();
    wait_halt("sub");
    push_exp("sub", 8'd5, 8'hFE, 0, 0, 0, 1);
    repeat (3) tick();
    push_exp("halt_hold", 8'd5, 8'hFE, 0, 0, 0, 1);
    dwr(3, 8'h5A);
    pulse_start();
    wait_halt("resume");
    push_exp("resume", 8'd7, 8'h5A, 0, 0, 0, 1);

    // Branch conditions: NZ skipped with Z=1, C taken after ADD overflow.
    do_reset();
    clear_prog();
    prog[0] = mk(L,  0, AL,  0, 8'h00);
    prog[1] = mk(L,  0, CNZ, 0, 8'h77);
    prog[3] = mk(L,  0, AL,  0, 8'h80);
    prog[4] = mk(AD, 0, AL,  0, 8'h80);
    prog[5] = mk(L,  1, CC,  0, 8'd20);
    prog[6] = mk(L,  0, AL,  0, 8'h66);
    load_prog();
    pulse_start();
    wait_halt("br_nz");
    push_exp("br_nz", 8'd2, 8'h00, 1, 0, 0, 1);
    pulse_start();
    wait_halt("br_c");
    push_exp("br_c", 8'd20, 8'h00, 0, 1, 0, 1);

    // Host writes ignored during RUN, reset mid-run, write+start same edge.
    do_reset();
    clear_prog();
    prog[0]  = mk(L, 0, AL, 1, 8'd2);
    prog[1]  = mk(L, 1, AL, 0, 8'd1);
    prog[10] = mk(L, 0, AL, 1, 8'd2);
    load_prog();
    dwr(2, 8'h33);
    pulse_start();
    repeat (3) tick();
    push_exp("loop", 8'd1, 8'h33, 0, 0, 1, 0);
    sb[$].chk_inst = 1'b1;
    sb[$].inst = mk(L, 1, AL, 0, 8'd1);
    sb[$].chk_abd = 1'b1;
    sb[$].a = 8'd1; sb[$].b = 8'd1; sb[$].d = 8'd1;
    pwr(10, mk(L, 0, AL, 0, 8'h99));
    dwr(2, 8'hAA);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_exp("mid_reset", 8'd0, 8'd0, 0, 0, 0, 0);
    bus.prog_we = 1'b1; bus.prog_addr = 8'd0; bus.prog_data = mk(L, 1, AL, 0, 8'd10);
    bus.start = 1'b1;
    tick();
    bus.prog_we = 1'b0; bus.start = 1'b0;
    wait_halt("mem_kept");
    push_exp("mem_kept", 8'd11, 8'h33, 0, 0, 0, 1);

    // Running past the last program word halts at pc == PMEM_DEPTH.
    do_reset();
    clear_prog();
    prog[0]  = mk(L, 1, AL, 0, 8'd30);
    prog[30] = mk(L, 0, AL, 0, 8'd7);
    prog[31] = mk(L, 0, AL, 0, 8'd9);
    load_prog();
    pulse_start();
    wait_halt("off_end");
    push_exp("off_end", 8'd32, 8'd9, 0, 0, 0, 1);
    sb[$].chk_inst = 1'b1;
    sb[$].inst = 15'h7FFF;

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
